// File: rtl/counter_monitor.sv
// Passive single-step checker for an up/down counter: predicts each next data_out
// from the sampled controls and the current data_out, and reports divergences.
module counter_monitor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cnt_reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             enable,
    input  logic             up_down,
    input  logic [WIDTH-1:0] data_out,
    output logic             synced,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] chk_count,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_act
);

    typedef enum logic {
        UNSYNC = 1'b0,
        TRACK  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [WIDTH-1:0] exp_val;

    // Reference counter step: cnt_reset beats load beats enable; wraps modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] predict(
        input logic [WIDTH-1:0] base,
        input logic             c_rst,
        input logic             c_load,
        input logic             c_en,
        input logic             c_up,
        input logic [WIDTH-1:0] c_din
    );
        logic [WIDTH-1:0] r;
        r = base;
        if (c_rst)
            r = '0;
        else if (c_load)
            r = c_din;
        else if (c_en)
            r = c_up ? base + 1'b1 : base - 1'b1;
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= UNSYNC;
            exp_val    <= '0;
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
            chk_count  <= '0;
            err_count  <= '0;
            first_exp  <= '0;
            first_act  <= '0;
        end else begin
            // Rebasing on the observed value makes a single fault cost exactly one mismatch.
            exp_val  <= predict(data_out, cnt_reset, load, enable, up_down, data_in);
            mismatch <= 1'b0;
            if (state == UNSYNC) begin
                if (cnt_reset || load)
                    state <= TRACK;
            end else begin
                if (chk_count != CNT_MAX)
                    chk_count <= chk_count + 1'b1;
                if (data_out != exp_val) begin
                    mismatch <= 1'b1;
                    if (err_count != CNT_MAX)
                        err_count <= err_count + 1'b1;
                    if (!err_sticky) begin
                        err_sticky <= 1'b1;
                        first_exp  <= exp_val;
                        first_act  <= data_out;
                    end
                end
            end
        end
    end

    assign synced = (state == TRACK);

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: emulates the observed counter (with injectable faults)
// and checks every monitor output each cycle against a behavioural model.
module tb_counter_monitor;

    localparam int WIDTH = 4;
    localparam int CNT_W = 5;
    localparam int CMAX  = 31;

    logic             clk;
    logic             reset;
    logic             cnt_reset;
    logic [WIDTH-1:0] data_in;
    logic             load;
    logic             enable;
    logic             up_down;
    logic [WIDTH-1:0] data_out;
    logic             synced;
    logic             mismatch;
    logic             err_sticky;
    logic [CNT_W-1:0] chk_count;
    logic [CNT_W-1:0] err_count;
    logic [WIDTH-1:0] first_exp;
    logic [WIDTH-1:0] first_act;

    counter_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cnt_reset  (cnt_reset),
        .data_in    (data_in),
        .load       (load),
        .enable     (enable),
        .up_down    (up_down),
        .data_out   (data_out),
        .synced     (synced),
        .mismatch   (mismatch),
        .err_sticky (err_sticky),
        .chk_count  (chk_count),
        .err_count  (err_count),
        .first_exp  (first_exp),
        .first_act  (first_act)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // emulated counter and behavioural model of the monitor
    int n_assert = 0;
    int n_fail   = 0;
    int cnt_val;
    int m_pred;
    bit m_synced;
    bit m_mis;
    bit m_sticky;
    int m_chk;
    int m_err;
    int m_fexp;
    int m_fact;
    int pulses;

    function automatic int next_val(int base);
        if (cnt_reset) return 0;
        if (load)      return int'(data_in);
        if (enable)    return up_down ? (base + 1) % 16 : (base + 15) % 16;
        return base;
    endfunction

    task automatic model_edge();
        int obs;
        obs = int'(data_out);
        if (reset) begin
            m_synced = 0; m_mis = 0; m_sticky = 0;
            m_chk = 0; m_err = 0; m_fexp = 0; m_fact = 0; m_pred = 0;
        end else begin
            m_mis = 0;
            if (m_synced) begin
                m_chk = (m_chk < CMAX) ? m_chk + 1 : CMAX;
                if (obs != m_pred) begin
                    m_mis = 1;
                    m_err = (m_err < CMAX) ? m_err + 1 : CMAX;
                    if (!m_sticky) begin
                        m_sticky = 1; m_fexp = m_pred; m_fact = obs;
                    end
                end
            end
            if (cnt_reset || load) m_synced = 1;
            m_pred = next_val(obs);
        end
        cnt_val = next_val(cnt_val);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        check("synced",     32'(synced),     32'(m_synced));
        check("mismatch",   32'(mismatch),   32'(m_mis));
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
        check("chk_count",  32'(chk_count),  32'(m_chk));
        check("err_count",  32'(err_count),  32'(m_err));
        check("first_exp",  32'(first_exp),  32'(m_fexp));
        check("first_act",  32'(first_act),  32'(m_fact));
        if (mismatch === 1'b1) pulses++;
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        data_out = WIDTH'(cnt_val);
        check_all();
    endtask

    task automatic corrupt(input int v);
        cnt_val  = v;
        data_out = WIDTH'(v);
    endtask

    task automatic set_ctl(input bit cr, input bit ld, input bit en, input bit ud, input int din);
        cnt_reset = cr; load = ld; enable = en; up_down = ud; data_in = WIDTH'(din);
    endtask

    initial begin
        reset = 1'b1;
        set_ctl(0, 0, 0, 0, 0);
        cnt_val = 9;
        data_out = 4'h9;
        pulses = 0;

        // reset, then unsynced for 5 cycles with arbitrary data_out
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            corrupt(int'($urandom_range(0, 15)));
            tick();
        end
        check("unsync_chk", 32'(chk_count), 32'd0);

        // sync via cnt_reset, count up 18 with wrap
        set_ctl(1, 0, 0, 1, 0);
        tick();
        set_ctl(0, 0, 1, 1, 0);
        for (int i = 0; i < 18; i++) tick();
        check("up_chk18", 32'(chk_count), 32'd18);
        check("up_err0",  32'(err_count), 32'd0);
        check("up_pulses", 32'(pulses), 32'd0);

        // load 3, count down through 0 -> F
        set_ctl(0, 1, 0, 0, 3);
        tick();
        set_ctl(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        check("down_val", 32'(data_out), 32'hE);
        check("down_pulses", 32'(pulses), 32'd0);

        // hold at 5, inject a single fault to 7
        set_ctl(0, 1, 0, 0, 5);
        tick();
        set_ctl(0, 0, 0, 0, 0);
        tick();
        corrupt(7);
        for (int i = 0; i < 4; i++) tick();
        check("fault_pulses", 32'(pulses), 32'd1);
        check("fault_err",    32'(err_count), 32'd1);
        check("fault_fexp",   32'(first_exp), 32'd5);
        check("fault_fact",   32'(first_act), 32'd7);
        check("fault_sticky", 32'(err_sticky), 32'd1);

        // priority: load beats enable, cnt_reset beats load
        set_ctl(0, 1, 0, 0, 2);
        tick();
        set_ctl(0, 1, 1, 1, 9);
        tick();
        check("load_wins", 32'(data_out), 32'd9);
        set_ctl(1, 1, 0, 0, 6);
        tick();
        set_ctl(0, 0, 0, 0, 0);
        tick();
        check("rst_wins", 32'(data_out), 32'd0);
        check("prio_pulses", 32'(pulses), 32'd1);

        // random controls with frequent faults, no monitor reset: counters saturate
        for (int i = 0; i < 150; i++) begin
            set_ctl($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)));
            tick();
            if ($urandom_range(0, 2) == 0) corrupt(int'($urandom_range(0, 15)));
        end
        check("chk_sat", 32'(chk_count), 32'(CMAX));

        // monitor reset discards everything; resync only on load
        set_ctl(0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_sticky", 32'(err_sticky), 32'd0);
        check("rst_err",    32'(err_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            corrupt(int'($urandom_range(0, 15)));
            tick();
        end
        check("rst_unsync", 32'(synced), 32'd0);
        set_ctl(0, 1, 0, 0, 4);
        tick();
        set_ctl(0, 0, 1, 1, 0);
        tick();
        check("resync", 32'(synced), 32'd1);

        // random run including occasional monitor resets
        for (int i = 0; i < 200; i++) begin
            reset = ($urandom_range(0, 29) == 0);
            set_ctl($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)));
            tick();
            if ($urandom_range(0, 5) == 0) corrupt(int'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
